multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Moore FSM that sequences the shared datapath one instruction at a time:
//  fetch, decode, execute, memory, writeback.
//  One ALU and one unified memory port are reused across cycles.
//  Decodes Opcode[5:0] from the instruction register and drives the datapath
//  mux selects and write enables.
//  Sits between IR/memory interface and the ALU/register-file/PC datapath.
// PARAMETERS
//  STATE_W    4     width of State output/encoding
//  MEM_TO_MAX 15    max cycles waiting on MemReady before MemTimeout (0 = no timeout)
// PORTS
//  clk            in   1  rising-edge clock
//  rst            in   1  synchronous, active-high reset
//  Opcode         in   6  IR[31:26], valid from DECODE onward
//  MemReady       in   1  memory completed current read/write this cycle
//  AluDone        in   1  multi-cycle MUL/DIV result valid (used only with MULDIV_WAIT_EN)
//  PCWrite        out  1  unconditional PC load
//  PCWriteCond    out  1  PC load if ALU Zero (BEQ)
//  IorD           out  1  0=PC addresses memory, 1=ALUOut addresses memory
//  MemRead        out  1  memory read strobe
//  MemToWrite     out  1  memory write strobe
//  IRWrite        out  1  latch instruction register
//  MemToReg       out  1  1=MDR to register file, 0=ALUOut
//  RegisterWrite  out  1  register-file write enable
//  RegDst         out  1  1=rd, 0=rt
//  ALUSrcA        out  1  0=PC, 1=rs
//  ALUSrcB        out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
//  ALUOp          out  3  000=add, 001=sub, 010=funct decode
//  PCSource       out  2  00=ALU result, 01=ALUOut, 10=jump target
//  IllegalOp      out  1  one-cycle pulse: unsupported opcode decoded
//  MemTimeout     out  1  one-cycle pulse: MemReady not seen within MEM_TO_MAX
//  State          out  STATE_W  current state, for debug
// BEHAVIOUR
//  - rst=1 at a clock edge: State<=RESET(0), timeout counter<=0. Mid-instruction aborts; no writes complete.
//  - In RESET every output is 0. RESET->FETCH unconditionally.
//  - All outputs are a pure function of State (Moore). Unlisted outputs are 0.
//  - FETCH(1): MemRead, IRWrite, PCWrite; ALUSrcA=0, ALUSrcB=01, ALUOp=000.
//    Holds until MemReady=1, then ->DECODE. IRWrite/PCWrite are asserted only in the MemReady cycle.
//  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target precompute).
//    Next state by Opcode:
//      000000 (R) or 011100 (MUL) -> EXEC
//      100011 (LW) or 101011 (SW) -> MADDR
//      000100 (BEQ)               -> BRANCH
//      001000 (ADDI)              -> IEXEC
//      000010 (J)                 -> JUMP
//      other                      -> FETCH, with IllegalOp=1 for that one cycle
//  - MADDR(3): ALUSrcA=1, ALUSrcB=10, ALUOp=000. LW->MREAD, SW->MWRITE.
//  - MREAD(4): MemRead, IorD=1; hold until MemReady, then ->MWB.
//  - MWB(5): RegisterWrite, MemToReg=1, RegDst=0; ->FETCH.
//  - MWRITE(6): MemToWrite, IorD=1; hold until MemReady, then ->FETCH.
//  - EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOp=010; ->RWB.
//  - RWB(8): RegisterWrite, RegDst=1, MemToReg=0; ->FETCH.
//  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond, PCSource=01; ->FETCH.
//  - JUMP(10): PCWrite, PCSource=10; ->FETCH.
//  - IEXEC(11): ALUSrcA=1, ALUSrcB=10, ALUOp=000; ->IWB.
//  - IWB(12): RegisterWrite, RegDst=0, MemToReg=0; ->FETCH.
//  - Latencies (cycles, MemReady immediate): R/MUL 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4.
//  - Memory wait: 4-bit counter counts cycles spent in FETCH/MREAD/MWRITE with MemReady=0.
//    It clears on state change.
//    If MEM_TO_MAX!=0 and the counter reaches MEM_TO_MAX: MemTimeout pulses 1 cycle,
//    then ->FETCH with no PC/IR/register/memory write.
//  - MemReady is ignored in all other states. States 13-15 are unreachable; if entered ->RESET.
// CONFIGURATION
//  MULDIV_WAIT_EN defined:
//    - EXEC for Opcode 011100, or Opcode 000000, goes to MDWAIT(13) instead of RWB.
//    - MDWAIT drives the EXEC outputs and holds until AluDone=1, then ->RWB.
//  MULDIV_WAIT_EN undefined:
//    - AluDone is ignored; EXEC->RWB always. State 13 is unused.
// TESTING
//  1. rst=1 for 2 cycles, then release -> all outputs 0 in RESET; State=1 next cycle; MemRead=1, IRWrite=0 until MemReady.
//  2. R-type add, Opcode=000000, MemReady=1 -> states 1,2,7,8,1; RegisterWrite=1, RegDst=1 only in state 8.
//  3. LW, Opcode=100011, MemReady low 3 cycles in MREAD -> states 1,2,3,4,4,4,4,5,1; MemToReg=1 in state 5.
//  4. Opcode=111111 -> IllegalOp=1 in DECODE cycle, next State=1, no RegisterWrite/MemToWrite.
//  5. SW with MemReady held 0, MEM_TO_MAX=15 -> MemTimeout pulse after 15 cycles in state 6, ->FETCH, MemToWrite drops.
//  6. rst=1 mid-MREAD -> State=0 next cycle, all outputs 0; with MULDIV_WAIT_EN, MUL waits in 13 until AluDone=1.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback on a shared datapath.
// Optional build macro MULDIV_WAIT_EN adds the MDWAIT state that holds EXEC until AluDone.
module multicycle_control_fsm #(
    parameter int unsigned STATE_W    = 4,
    parameter int unsigned MEM_TO_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Opcode,
    input  logic               MemReady,
    input  logic               AluDone,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemToWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegisterWrite,
    output logic               RegDst,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               IllegalOp,
    output logic               MemTimeout,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MADDR  = 4'd3,
        S_MREAD  = 4'd4,
        S_MWB    = 4'd5,
        S_MWRITE = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_MDWAIT = 4'd13
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_MUL  = 6'b011100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic       mem_wait;
    logic       timeout_hit;

    assign mem_wait    = (state == S_FETCH) || (state == S_MREAD) || (state == S_MWRITE);
    // Timeout wins over a late MemReady: once the budget is spent the access is abandoned.
    assign timeout_hit = (MEM_TO_MAX != 0) && mem_wait && (wait_cnt == 4'(MEM_TO_MAX));
    assign State       = STATE_W'(state);

`ifndef MULDIV_WAIT_EN
    logic unused_aludone;
    assign unused_aludone = AluDone;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RESET;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (!mem_wait || timeout_hit || next_state != state) begin
                wait_cnt <= '0;
            end else if (!MemReady && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        next_state    = state;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemToWrite    = 1'b0;
        IRWrite       = 1'b0;
        MemToReg      = 1'b0;
        RegisterWrite = 1'b0;
        RegDst        = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 3'b000;
        PCSource      = 2'b00;
        IllegalOp     = 1'b0;
        MemTimeout    = 1'b0;

        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (timeout_hit) begin
                    MemTimeout = 1'b1;
                    next_state = S_FETCH;
                end else if (MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_R, OP_MUL:  next_state = S_EXEC;
                    OP_LW, OP_SW:  next_state = S_MADDR;
                    OP_BEQ:        next_state = S_BRANCH;
                    OP_ADDI:       next_state = S_IEXEC;
                    OP_J:          next_state = S_JUMP;
                    default: begin
                        IllegalOp  = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (Opcode == OP_LW) ? S_MREAD : S_MWRITE;
            end
            S_MREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (timeout_hit) begin
                    MemTimeout = 1'b1;
                    next_state = S_FETCH;
                end else if (MemReady) begin
                    next_state = S_MWB;
                end
            end
            S_MWB: begin
                RegisterWrite = 1'b1;
                MemToReg      = 1'b1;
                next_state    = S_FETCH;
            end
            S_MWRITE: begin
                MemToWrite = 1'b1;
                IorD       = 1'b1;
                if (timeout_hit) begin
                    MemTimeout = 1'b1;
                    next_state = S_FETCH;
                end else if (MemReady) begin
                    next_state = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 3'b010;
`ifdef MULDIV_WAIT_EN
                next_state = (Opcode == OP_MUL || Opcode == OP_R) ? S_MDWAIT : S_RWB;
`else
                next_state = S_RWB;
`endif
            end
`ifdef MULDIV_WAIT_EN
            S_MDWAIT: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
                if (AluDone) begin
                    next_state = S_RWB;
                end
            end
`endif
            S_RWB: begin
                RegisterWrite = 1'b1;
                RegDst        = 1'b1;
                next_state    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                next_state  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                next_state = S_FETCH;
            end
            S_IEXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = S_IWB;
            end
            S_IWB: begin
                RegisterWrite = 1'b1;
                next_state    = S_FETCH;
            end
            default: next_state = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: builds an expected per-cycle trace from instruction-level rules and replays it.
module tb_multicycle_control_fsm;

    localparam int unsigned TO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Opcode = '0;
    logic       MemReady = 1'b0;
    logic       AluDone = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite, MemToReg;
    logic       RegisterWrite, RegDst, ALUSrcA, IllegalOp, MemTimeout;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;

    multicycle_control_fsm #(.STATE_W(4), .MEM_TO_MAX(TO)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .MemReady(MemReady), .AluDone(AluDone),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemToWrite(MemToWrite), .IRWrite(IRWrite), .MemToReg(MemToReg),
        .RegisterWrite(RegisterWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .IllegalOp(IllegalOp),
        .MemTimeout(MemTimeout), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic ill, mto;
    } outs_t;

    typedef struct {
        bit         rst;
        bit         chk;
        bit         mr;
        bit         ad;
        logic [5:0] op;
        logic [3:0] st;
        outs_t      o;
    } cyc_t;

    outs_t obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemToWrite, IRWrite, MemToReg,
                  RegisterWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, MemTimeout};

    cyc_t tr[$];
    int   checks = 0;
    int   errors = 0;
    logic [5:0] legal [7] = '{6'b000000, 6'b011100, 6'b100011, 6'b101011,
                              6'b000100, 6'b001000, 6'b000010};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic push(input logic [3:0] st, input outs_t o, input logic [5:0] op,
                        input bit mr, input bit ad);
        cyc_t c;
        c.rst = 1'b0; c.chk = 1'b1; c.mr = mr; c.ad = ad; c.op = op; c.st = st; c.o = o;
        tr.push_back(c);
    endtask

    // w = cycles of MemReady low before it rises; w >= TO abandons the access.
    task automatic mem_phase(input logic [3:0] st, input outs_t busy, input outs_t done,
                             input logic [5:0] op, input int unsigned w, output bit to);
        outs_t o;
        to = 1'b0;
        if (TO != 0 && w >= TO) begin
            for (int unsigned i = 0; i < TO; i++) push(st, busy, op, 1'b0, rb());
            o = busy; o.mto = 1'b1;
            push(st, o, op, 1'b0, rb());
            to = 1'b1;
        end else begin
            for (int unsigned i = 0; i < w; i++) push(st, busy, op, 1'b0, rb());
            push(st, done, op, 1'b1, rb());
        end
    endtask

    task automatic gen_instr(input logic [5:0] op, input int unsigned fw, input int unsigned mw);
        outs_t o, d;
        bit    to;
        o = '0; o.mrd = 1'b1; o.asb = 2'b01;
        d = o;  d.irw = 1'b1; d.pcw = 1'b1;
        mem_phase(4'd1, o, d, 6'($urandom), fw, to);
        if (to) return;
        o = '0; o.asb = 2'b11;
        if (!(op inside {legal})) begin
            o.ill = 1'b1;
            push(4'd2, o, op, rb(), rb());
            return;
        end
        push(4'd2, o, op, rb(), rb());
        o = '0;
        case (op)
            6'b000000, 6'b011100: begin
                o.asa = 1'b1; o.aop = 3'b010;
                push(4'd7, o, op, rb(), rb());
`ifdef MULDIV_WAIT_EN
                begin
                    int unsigned kw = $urandom_range(0, 4);
                    for (int unsigned i = 0; i < kw; i++) push(4'd13, o, op, rb(), 1'b0);
                    push(4'd13, o, op, rb(), 1'b1);
                end
`endif
                o = '0; o.rw = 1'b1; o.rdst = 1'b1;
                push(4'd8, o, op, rb(), rb());
            end
            6'b100011: begin
                o.asa = 1'b1; o.asb = 2'b10;
                push(4'd3, o, op, rb(), rb());
                o = '0; o.mrd = 1'b1; o.iord = 1'b1;
                mem_phase(4'd4, o, o, op, mw, to);
                if (!to) begin
                    o = '0; o.rw = 1'b1; o.m2r = 1'b1;
                    push(4'd5, o, op, rb(), rb());
                end
            end
            6'b101011: begin
                o.asa = 1'b1; o.asb = 2'b10;
                push(4'd3, o, op, rb(), rb());
                o = '0; o.mwr = 1'b1; o.iord = 1'b1;
                mem_phase(4'd6, o, o, op, mw, to);
            end
            6'b000100: begin
                o.asa = 1'b1; o.aop = 3'b001; o.pcwc = 1'b1; o.pcs = 2'b01;
                push(4'd9, o, op, rb(), rb());
            end
            6'b000010: begin
                o.pcw = 1'b1; o.pcs = 2'b10;
                push(4'd10, o, op, rb(), rb());
            end
            default: begin
                o.asa = 1'b1; o.asb = 2'b10;
                push(4'd11, o, op, rb(), rb());
                o = '0; o.rw = 1'b1;
                push(4'd12, o, op, rb(), rb());
            end
        endcase
    endtask

    // Reset asserted during cycle idx: trace after it is discarded, then RESET, then FETCH.
    task automatic abort_at(input int unsigned idx);
        while (tr.size() > idx + 1) void'(tr.pop_back());
        tr[idx].rst = 1'b1;
        push(4'd0, '0, 6'($urandom), rb(), rb());
    endtask

    function automatic int unsigned rand_wait();
        return ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 3);
    endfunction

    initial begin
        cyc_t        c;
        int unsigned s;
        logic [5:0]  op;

        c.rst = 1'b1; c.chk = 1'b0; c.mr = 1'b0; c.ad = 1'b0; c.op = '0; c.st = '0; c.o = '0;
        tr.push_back(c);
        c.chk = 1'b1;
        tr.push_back(c);
        push(4'd0, '0, 6'd0, 1'b1, 1'b0);

        gen_instr(6'b000000, 0, 0);
        gen_instr(6'b100011, 0, 3);
        gen_instr(6'b111111, 0, 0);
        gen_instr(6'b101011, 0, TO + 5);
        gen_instr(6'b001000, TO + 1, 0);
        s = tr.size();
        gen_instr(6'b100011, 0, 5);
        abort_at(s + 5);
        gen_instr(6'b000100, 0, 0);
        gen_instr(6'b000010, 0, 0);

        for (int n = 0; n < 150; n++) begin
            s  = tr.size();
            op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : legal[$urandom_range(0, 6)];
            gen_instr(op, rand_wait(), rand_wait());
            if ($urandom_range(0, 7) == 0 && tr.size() > s)
                abort_at($urandom_range(s, tr.size() - 1));
        end

        foreach (tr[i]) begin
            @(negedge clk);
            rst      = tr[i].rst;
            MemReady = tr[i].mr;
            AluDone  = tr[i].ad;
            Opcode   = tr[i].op;
            #1;
            if (tr[i].chk) begin
                check($sformatf("state@%0d", i), 32'(State), 32'(tr[i].st));
                check($sformatf("outs@%0d", i), 32'(obs), 32'(tr[i].o));
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
